// File: rtl/if_stage_hs.sv
// ---------------------------------------------------------------------------
// if_stage_hs
//   Instruction-fetch stage with an IF/ID output register. It owns the PC,
//   fetches from a variable-latency instruction memory, and handles hazard
//   stalls (freeze), branch redirect/flush from EXE and the cancellation of
//   in-flight fetches.
//
// Optional feature macro: IF_PERF_COUNT_EN. When it is defined, the block has
//   three 32-bit performance counter outputs. When it is undefined, those ports
//   and their logic are absent.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   freeze                hazard stall, holds the IF/ID register
//   br_taken, br_pc,      taken branch from EXE: target is
//   br_offset               br_pc + (sext(br_offset) << 2)
//   imem_req, imem_addr   fetch request and address towards memory
//   imem_ready,           fetch completes this cycle with imem_rdata
//   imem_rdata
//   valid_out, instr_out, IF/ID register (pc_out is the PC+4 of instr_out)
//   pc_out
//   state_dbg             current FSM state (FETCH=0, SKID=1, DROP=2)
//   fetch_cnt, flush_cnt, perf counters (IF_PERF_COUNT_EN only)
//   stall_cnt
//
// Handshake: a fetch completes on a rising edge where imem_req and imem_ready
//   are both 1. While imem_req is 1 and imem_ready is 0, imem_addr is held
//   stable. This also holds across freeze and br_taken. A request is withdrawn
//   only on reset.
// ---------------------------------------------------------------------------
module if_stage_hs #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              OFF_W    = 16,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_pc,
  input  logic [OFF_W-1:0]   br_offset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               valid_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [1:0]         state_dbg
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SKID  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    drop_addr;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  logic [PC_W-1:0]    next_pc;
  logic [PC_W-1:0]    off_ext;
  logic [PC_W-1:0]    target;
  logic               complete;

  // Both additions wrap modulo 2^PC_W without any check.
  assign next_pc  = pc + {{(PC_W-3){1'b0}}, 3'd4};
  assign off_ext  = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
  assign target   = br_pc + (off_ext << 2);

  // The request drops immediately when reset is asserted, so an outstanding
  // fetch is abandoned without waiting for a clock edge.
  assign imem_req  = rst && (state != SKID);
  // DROP keeps presenting the abandoned address until the memory finishes it.
  assign imem_addr = (state == DROP) ? drop_addr : pc;
  assign complete  = imem_req && imem_ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= PC_RESET;
      drop_addr  <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      valid_out  <= 1'b0;
      instr_out  <= '0;
      pc_out     <= '0;
    end else if (br_taken) begin
      // A redirect flushes the output and any skid entry. The branch has
      // priority over freeze.
      pc        <= target;
      valid_out <= 1'b0;
      case (state)
        FETCH: begin
          // A fetch that is still open cannot be withdrawn, so its address is
          // kept and its data is discarded later in DROP.
          if (!complete) begin
            drop_addr <= pc;
            state     <= DROP;
          end
        end
        SKID:    state <= FETCH;
        DROP:    if (complete) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (complete) begin
            pc <= next_pc;
            if (!freeze) begin
              valid_out <= 1'b1;
              instr_out <= imem_rdata;
              pc_out    <= next_pc;
            end else begin
              // ID cannot take the instruction yet, so it is parked here.
              skid_instr <= imem_rdata;
              skid_pc    <= next_pc;
              state      <= SKID;
            end
          end else if (!freeze) begin
            valid_out <= 1'b0;
          end
        end
        SKID: begin
          if (!freeze) begin
            valid_out <= 1'b1;
            instr_out <= skid_instr;
            pc_out    <= skid_pc;
            state     <= FETCH;
          end
        end
        DROP: begin
          if (!freeze) valid_out <= 1'b0;
          // The data for the abandoned address is not used. The next request
          // goes to pc, which already holds the branch target.
          if (complete) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IF_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      // Only completions in FETCH without a redirect reach ID.
      if (complete && (state == FETCH) && !br_taken) fetch_cnt <= fetch_cnt + 32'd1;
      if (br_taken) flush_cnt <= flush_cnt + 32'd1;
      if (freeze)   stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
